prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: takes a length-prefixed byte stream from a host and writes
// 32-bit little-endian instruction words into instruction memory, holding
// the core's PC in reset until the image is complete.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        En,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [15:0] words_written,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 64;

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        PAYLOAD = 3'd2,
        WRITE   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK     = 3'd4,
`endif
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    // State entered once the last word is committed (or the count is zero)
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t TAIL_ST = CHK;
`else
    localparam state_t TAIL_ST = DONE;
`endif

    state_t                state_q;
    state_t                state_d;
    logic [BYTE_W-1:0]     count_lo;
    logic [CNT_W-1:0]      word_count;
    logic [CNT_W-1:0]      hdr_count;
    logic [CNT_W-1:0]      ww_inc;
    logic [3*BYTE_W-1:0]   word_lo;
    logic [1:0]            byte_idx;
    logic                  accept;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]     csum;
`endif

    assign accept    = in_valid & in_ready;
    assign hdr_count = {in_data, count_lo};
    assign ww_inc    = words_written + CNT_W'(1);

    // State register
    always_ff @(posedge Clk or negedge En) begin
        if (!En) begin
            state_q <= HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR0: begin
                if (accept) state_d = HDR1;
            end
            HDR1: begin
                if (accept) begin
                    if (32'(hdr_count) > MAX_WORDS) state_d = ERR;
                    else if (hdr_count == '0)       state_d = TAIL_ST;
                    else                            state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept && byte_idx == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                if (ww_inc == word_count) state_d = TAIL_ST;
                else                      state_d = PAYLOAD;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_d = (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start) state_d = HDR0;
            end
            default: state_d = HDR0;
        endcase
    end

    // Moore output decode
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (state_q)
            HDR0, HDR1, PAYLOAD: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:                 in_ready = 1'b1;
`endif
            WRITE:               mem_we   = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:                 error    = 1'b1;
            default: ;
        endcase
    end

    // Header capture, word assembly, write address/data and word counter
    always_ff @(posedge Clk or negedge En) begin
        if (!En) begin
            count_lo      <= '0;
            word_count    <= '0;
            word_lo       <= '0;
            byte_idx      <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            if (state_q == HDR0 && accept) count_lo <= in_data;
            if (state_q == HDR1 && accept) word_count <= hdr_count;
            if (state_q == PAYLOAD && accept) begin
                word_lo  <= {in_data, word_lo[3*BYTE_W-1:BYTE_W]};
                byte_idx <= byte_idx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= csum ^ in_data;
`endif
                // Fourth byte completes the word: stage address and data for WRITE
                if (byte_idx == 2'd3) begin
                    mem_addr  <= BASE_ADDR + ADDR_W'({words_written, 2'b00});
                    mem_wdata <= {WORD_W'(0), in_data, word_lo};
                end
            end
            if (state_q == WRITE) words_written <= ww_inc;
            if ((state_q == DONE || state_q == ERR) && start) begin
                words_written <= '0;
                byte_idx      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum          <= '0;
`endif
            end
        end
    end

endmodule
